// File: rtl/riscv_if.sv
// Instruction fetch stage: issues word reads to instruction memory and presents instruction/pc to decode.
// Optional feature: define RISCV_IF_PREFETCH_EN for a 2-entry prefetch FIFO (1 insn/cycle).
module riscv_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid,
  output logic        exception
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;

  logic ack_v;
  logic slot_free;
  logic outstanding;

`ifdef RISCV_IF_PREFETCH_EN
  logic [1:0][31:0] fifo_insn_q, fifo_insn_d;
  logic [1:0][31:0] fifo_pc_q, fifo_pc_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             push;
  logic             pop;
`endif

  assign ack_v       = imem_ack && req_q;
  assign slot_free   = !valid_q || id_ready;
  assign outstanding = req_q && !imem_ack;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    insn_d     = insn_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    exc_d      = exc_q;
    fetch_pc_d = fetch_pc_q;

    if (valid_q && id_ready) begin
      valid_d = 1'b0;
      insn_d  = NOP_INSN;
    end

`ifdef RISCV_IF_PREFETCH_EN
    fifo_insn_d = fifo_insn_q;
    fifo_pc_d   = fifo_pc_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    push        = ack_v && (state_q == REQ);
    pop         = (cnt_q != 2'd0) && slot_free;

    if (pop) begin
      insn_d  = fifo_insn_q[rd_q];
      pc_d    = fifo_pc_q[rd_q];
      valid_d = 1'b1;
      rd_d    = ~rd_q;
    end
    if (push) begin
      fifo_insn_d[wr_q] = imem_rdata;
      fifo_pc_d[wr_q]   = fetch_pc_q;
      wr_d              = ~wr_q;
      fetch_pc_d        = fetch_pc_q + 32'd4;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end

    // A new request may start only if the FIFO can still hold it once it lands.
    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = fetch_pc_q;
      end
      REQ: begin
        if (!req_q || ack_v) begin
          if (cnt_d <= 2'd1) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_d;
          end else begin
            req_d = 1'b0;
          end
        end
      end
      DROP: begin
        if (ack_v) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      HALT: begin
        if (ack_v) begin
          req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    case (state_q)
      IDLE: begin
        if (slot_free) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (ack_v) begin
          insn_d     = imem_rdata;
          pc_d       = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          req_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      DROP: begin
        if (ack_v) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      HALT: begin
        if (ack_v) begin
          req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`endif

    // An unacknowledged request must stay stable, so its data is dropped later instead.
    if (redirect) begin
      valid_d    = 1'b0;
      insn_d     = NOP_INSN;
      fetch_pc_d = redirect_pc;
`ifdef RISCV_IF_PREFETCH_EN
      cnt_d = 2'd0;
      rd_d  = 1'b0;
      wr_d  = 1'b0;
`endif
      if (redirect_pc[1:0] != 2'b00) begin
        exc_d   = 1'b1;
        state_d = HALT;
        req_d   = outstanding;
      end else begin
        exc_d = 1'b0;
        if (outstanding) begin
          state_d = DROP;
          req_d   = 1'b1;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = redirect_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      insn_q     <= NOP_INSN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      exc_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
`ifdef RISCV_IF_PREFETCH_EN
      fifo_insn_q <= '0;
      fifo_pc_q   <= '0;
      cnt_q       <= 2'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      insn_q     <= insn_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      exc_q      <= exc_d;
      fetch_pc_q <= fetch_pc_d;
`ifdef RISCV_IF_PREFETCH_EN
      fifo_insn_q <= fifo_insn_d;
      fifo_pc_q   <= fifo_pc_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = insn_q;
  assign pc          = pc_q;
  assign valid       = valid_q;
  assign exception   = exc_q;

endmodule
